// File: rtl/iod_rx_train_sequencer.sv
// ---------------------------------------------------------------------------
// iod_rx_train_sequencer
//
// Purpose:
//   Sequences RX interface training on SCLK. It sits directly upstream of the
//   BCLK/SCLK clock-align block. It qualifies PLL lock, then runs clock
//   alignment. On success it starts bit alignment. On error or timeout it
//   pulses CLK_ALGN_RSTRT and retries, up to MAX_RETRY failed attempts. It
//   reports done/fail status to the fabric.
//
// Ports:
//   SCLK                  in   system clock
//   RESETN                in   asynchronous active-low reset
//   PLL_LOCK              in   PLL lock, asynchronous to SCLK
//   SW_RSTRT              in   single-cycle software restart (DONE/FAIL only)
//   BCLKSCLK_TRAIN_DONE   in   clock-align complete (level)
//   ICB_CLK_ALGN_ERR      in   clock-align error (level)
//   BIT_ALGN_DONE         in   bit-align complete (level)
//   BCLKSCLK_TRAIN_START  out  high while in CLK_TRAIN
//   CLK_ALGN_RSTRT        out  one-cycle pulse in RETRY / RSTRT
//   BIT_ALGN_START        out  high while in BIT_TRAIN
//   TRAIN_DONE            out  high in DONE
//   TRAIN_ERR             out  high in FAIL
//   RETRY_CNT             out  failed attempts since last clear (saturating)
//   ERR_EVENT_CNT         out  saturating count of RETRY entries
//                              (only when IOD_RX_TRAIN_SEQ_ERRCNT_EN is defined)
//   SEQ_STATE             out  current state encoding (debug)
//
// Build option:
//   IOD_RX_TRAIN_SEQ_ERRCNT_EN - adds ERR_EVENT_CNT. Only RESETN clears it.
// ---------------------------------------------------------------------------
module iod_rx_train_sequencer #(
    parameter int LOCK_SYNC_STAGES      = 2,
    parameter int LOCK_STABLE_CNT_WIDTH = 8,
    parameter int TIMEOUT_CNT_WIDTH     = 16,
    parameter int MAX_RETRY             = 3,
    parameter int RETRY_CNT_WIDTH       = 2
) (
    input  logic                       SCLK,
    input  logic                       RESETN,
    input  logic                       PLL_LOCK,
    input  logic                       SW_RSTRT,
    input  logic                       BCLKSCLK_TRAIN_DONE,
    input  logic                       ICB_CLK_ALGN_ERR,
    input  logic                       BIT_ALGN_DONE,
    output logic                       BCLKSCLK_TRAIN_START,
    output logic                       CLK_ALGN_RSTRT,
    output logic                       BIT_ALGN_START,
    output logic                       TRAIN_DONE,
    output logic                       TRAIN_ERR,
    output logic [RETRY_CNT_WIDTH-1:0] RETRY_CNT,
`ifdef IOD_RX_TRAIN_SEQ_ERRCNT_EN
    output logic [7:0]                 ERR_EVENT_CNT,
`endif
    output logic [2:0]                 SEQ_STATE
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOCK_WAIT = 3'd1,
        CLK_TRAIN = 3'd2,
        BIT_TRAIN = 3'd3,
        RETRY     = 3'd4,
        DONE      = 3'd5,
        FAIL      = 3'd6,
        RSTRT     = 3'd7
    } state_t;

    localparam logic [LOCK_STABLE_CNT_WIDTH-1:0] STABLE_ONE  = 1;
    localparam logic [TIMEOUT_CNT_WIDTH-1:0]     TIMEOUT_ONE = 1;
    localparam logic [RETRY_CNT_WIDTH:0]         RETRY_ONE   = 1;
    localparam logic [RETRY_CNT_WIDTH:0]         MAX_RETRY_L = (RETRY_CNT_WIDTH+1)'(MAX_RETRY);

    state_t                           state_q, state_d;
    logic [LOCK_SYNC_STAGES-1:0]      lock_sync_q, lock_sync_d;
    logic [LOCK_STABLE_CNT_WIDTH-1:0] stable_cnt_q, stable_cnt_d;
    logic [TIMEOUT_CNT_WIDTH-1:0]     timeout_cnt_q, timeout_cnt_d;
    logic [RETRY_CNT_WIDTH-1:0]       retry_cnt_q, retry_cnt_d;
    logic                             start_q, start_d;
    logic                             rstrt_q, rstrt_d;
    logic                             bit_start_q, bit_start_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;
    logic                             lock_s;
    logic                             lock_lost;
    logic [RETRY_CNT_WIDTH:0]         retry_inc;

    // PLL_LOCK enters at bit 0 and shifts toward the MSB.
    assign lock_sync_d = {lock_sync_q[LOCK_SYNC_STAGES-2:0], PLL_LOCK};
    assign lock_s      = lock_sync_q[LOCK_SYNC_STAGES-1];
    assign lock_lost   = (state_q != IDLE) && !lock_s;
    // One bit wider so that "count + 1" can be compared with MAX_RETRY
    // without overflowing.
    assign retry_inc   = {1'b0, retry_cnt_q} + RETRY_ONE;

    always_comb begin
        state_d = state_q;
        if (lock_lost) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (lock_s) state_d = LOCK_WAIT;
                LOCK_WAIT: if (&stable_cnt_q) state_d = CLK_TRAIN;
                CLK_TRAIN: begin
                    if (ICB_CLK_ALGN_ERR)         state_d = RETRY;
                    else if (BCLKSCLK_TRAIN_DONE) state_d = BIT_TRAIN;
                    else if (&timeout_cnt_q)      state_d = RETRY;
                end
                BIT_TRAIN: begin
                    if (BIT_ALGN_DONE)       state_d = DONE;
                    else if (&timeout_cnt_q) state_d = RETRY;
                end
                RETRY:     state_d = (retry_inc == MAX_RETRY_L) ? FAIL : LOCK_WAIT;
                DONE:      if (SW_RSTRT) state_d = RSTRT;
                FAIL:      if (SW_RSTRT) state_d = RSTRT;
                RSTRT:     state_d = LOCK_WAIT;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        // Both counters restart from zero whenever their state is (re)entered.
        stable_cnt_d = '0;
        if (state_q == LOCK_WAIT && state_d == LOCK_WAIT)
            stable_cnt_d = stable_cnt_q + STABLE_ONE;

        timeout_cnt_d = '0;
        if ((state_q == CLK_TRAIN || state_q == BIT_TRAIN) && state_d == state_q && !(&timeout_cnt_q))
            timeout_cnt_d = timeout_cnt_q + TIMEOUT_ONE;

        // A lock loss leaves the retry count untouched.
        retry_cnt_d = retry_cnt_q;
        if (!lock_lost) begin
            if (state_q == RETRY && !(&retry_cnt_q))
                retry_cnt_d = retry_inc[RETRY_CNT_WIDTH-1:0];
            else if (state_q == RSTRT)
                retry_cnt_d = '0;
        end

        // Outputs are decoded from the next state. As a result, they change on
        // the same edge as SEQ_STATE.
        start_d     = (state_d == CLK_TRAIN);
        bit_start_d = (state_d == BIT_TRAIN);
        rstrt_d     = (state_d == RETRY) || (state_d == RSTRT);
        done_d      = (state_d == DONE);
        err_d       = (state_d == FAIL);
    end

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q       <= IDLE;
            lock_sync_q   <= '0;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            retry_cnt_q   <= '0;
            start_q       <= 1'b0;
            rstrt_q       <= 1'b0;
            bit_start_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_sync_q   <= lock_sync_d;
            stable_cnt_q  <= stable_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            start_q       <= start_d;
            rstrt_q       <= rstrt_d;
            bit_start_q   <= bit_start_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

`ifdef IOD_RX_TRAIN_SEQ_ERRCNT_EN
    logic [7:0] err_event_cnt_q, err_event_cnt_d;

    always_comb begin
        err_event_cnt_d = err_event_cnt_q;
        if (state_d == RETRY && state_q != RETRY && err_event_cnt_q != 8'hFF)
            err_event_cnt_d = err_event_cnt_q + 8'd1;
    end

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) err_event_cnt_q <= 8'd0;
        else         err_event_cnt_q <= err_event_cnt_d;
    end

    assign ERR_EVENT_CNT = err_event_cnt_q;
`endif

    assign BCLKSCLK_TRAIN_START = start_q;
    assign CLK_ALGN_RSTRT       = rstrt_q;
    assign BIT_ALGN_START       = bit_start_q;
    assign TRAIN_DONE           = done_q;
    assign TRAIN_ERR            = err_q;
    assign RETRY_CNT            = retry_cnt_q;
    assign SEQ_STATE            = state_q;

endmodule

// File: tb/tb_iod_rx_train_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iod_rx_train_sequencer
//
// Directed bench for iod_rx_train_sequencer. It uses LOCK_STABLE_CNT_WIDTH=4,
// TIMEOUT_CNT_WIDTH=6 and MAX_RETRY=2. Inputs change 1 time unit after a
// rising edge, and outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_iod_rx_train_sequencer;

    logic       SCLK = 1'b0;
    logic       RESETN;
    logic       PLL_LOCK;
    logic       SW_RSTRT;
    logic       BCLKSCLK_TRAIN_DONE;
    logic       ICB_CLK_ALGN_ERR;
    logic       BIT_ALGN_DONE;
    logic       BCLKSCLK_TRAIN_START;
    logic       CLK_ALGN_RSTRT;
    logic       BIT_ALGN_START;
    logic       TRAIN_DONE;
    logic       TRAIN_ERR;
    logic [1:0] RETRY_CNT;
    logic [2:0] SEQ_STATE;
`ifdef IOD_RX_TRAIN_SEQ_ERRCNT_EN
    logic [7:0] ERR_EVENT_CNT;
`endif

    int vectors     = 0;
    int miscompares = 0;

    iod_rx_train_sequencer #(
        .LOCK_SYNC_STAGES     (2),
        .LOCK_STABLE_CNT_WIDTH(4),
        .TIMEOUT_CNT_WIDTH    (6),
        .MAX_RETRY            (2),
        .RETRY_CNT_WIDTH      (2)
    ) dut (
        .SCLK                (SCLK),
        .RESETN              (RESETN),
        .PLL_LOCK            (PLL_LOCK),
        .SW_RSTRT            (SW_RSTRT),
        .BCLKSCLK_TRAIN_DONE (BCLKSCLK_TRAIN_DONE),
        .ICB_CLK_ALGN_ERR    (ICB_CLK_ALGN_ERR),
        .BIT_ALGN_DONE       (BIT_ALGN_DONE),
        .BCLKSCLK_TRAIN_START(BCLKSCLK_TRAIN_START),
        .CLK_ALGN_RSTRT      (CLK_ALGN_RSTRT),
        .BIT_ALGN_START      (BIT_ALGN_START),
        .TRAIN_DONE          (TRAIN_DONE),
        .TRAIN_ERR           (TRAIN_ERR),
        .RETRY_CNT           (RETRY_CNT),
`ifdef IOD_RX_TRAIN_SEQ_ERRCNT_EN
        .ERR_EVENT_CNT       (ERR_EVENT_CNT),
`endif
        .SEQ_STATE           (SEQ_STATE)
    );

    always #5 SCLK = ~SCLK;

    task automatic step();
        @(posedge SCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("vector %0d %s: observed=%0d expected=%0d", vectors, tag, obs, exp);
    endtask

    // Steps until START rises, or until max steps have elapsed.
    task automatic wait_start(input int max, output int n);
        n = 0;
        while (!BCLKSCLK_TRAIN_START && n < max) begin
            step();
            n++;
        end
    endtask

    // Counts how many steps START stays high. The count includes the current
    // cycle.
    task automatic count_start_high(output int n);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (BCLKSCLK_TRAIN_START) n++;
            else break;
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({BCLKSCLK_TRAIN_START, CLK_ALGN_RSTRT, BIT_ALGN_START,
                    TRAIN_DONE, TRAIN_ERR, RETRY_CNT, SEQ_STATE});
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        RESETN = 1'b0; PLL_LOCK = 1'b0; SW_RSTRT = 1'b0;
        BCLKSCLK_TRAIN_DONE = 1'b0; ICB_CLK_ALGN_ERR = 1'b0; BIT_ALGN_DONE = 1'b0;
        repeat (3) step();
        check("reset_outputs", all_outs(), 0);
        RESETN = 1'b1;
        repeat (3) step();
        check("idle_no_lock", 32'(SEQ_STATE), 0);

        // Scenario 1: clean training.
        // Expected START latency is 19 edges:
        // 2 synchronizer edges + 1 IDLE exit edge + 16 LOCK_WAIT cycles.
        PLL_LOCK = 1'b1;
        wait_start(100, n);
        check("s1_start_latency", 32'(n), 19);
        check("s1_state_clk_train", 32'(SEQ_STATE), 2);
        repeat (4) step();
        check("s1_start_held", 32'(BCLKSCLK_TRAIN_START), 1);
        BCLKSCLK_TRAIN_DONE = 1'b1;
        step();
        BCLKSCLK_TRAIN_DONE = 1'b0;
        check("s1_state_bit_train", 32'(SEQ_STATE), 3);
        check("s1_bit_start", 32'(BIT_ALGN_START), 1);
        check("s1_start_dropped", 32'(BCLKSCLK_TRAIN_START), 0);
        repeat (2) step();
        BIT_ALGN_DONE = 1'b1;
        step();
        BIT_ALGN_DONE = 1'b0;
        check("s1_state_done", 32'(SEQ_STATE), 5);
        check("s1_train_done", 32'(TRAIN_DONE), 1);
        check("s1_bit_start_low", 32'(BIT_ALGN_START), 0);
        check("s1_retry_cnt", 32'(RETRY_CNT), 0);

        // SW restart from DONE.
        SW_RSTRT = 1'b1;
        step();
        SW_RSTRT = 1'b0;
        check("sw_done_state_rstrt", 32'(SEQ_STATE), 7);
        check("sw_done_rstrt_pulse", 32'(CLK_ALGN_RSTRT), 1);
        check("sw_done_train_done_low", 32'(TRAIN_DONE), 0);
        step();
        check("sw_done_lock_wait", 32'(SEQ_STATE), 1);
        check("sw_done_rstrt_end", 32'(CLK_ALGN_RSTRT), 0);
        wait_start(100, n);
        check("sw_done_start_latency", 32'(n), 16);

        // Scenario 2: error on the first attempt, then a clean second attempt.
        ICB_CLK_ALGN_ERR = 1'b1;
        step();
        ICB_CLK_ALGN_ERR = 1'b0;
        check("s2_state_retry", 32'(SEQ_STATE), 4);
        check("s2_rstrt_pulse", 32'(CLK_ALGN_RSTRT), 1);
        check("s2_start_low", 32'(BCLKSCLK_TRAIN_START), 0);
        step();
        check("s2_lock_wait", 32'(SEQ_STATE), 1);
        check("s2_retry_cnt", 32'(RETRY_CNT), 1);
        check("s2_rstrt_end", 32'(CLK_ALGN_RSTRT), 0);
        wait_start(100, n);
        check("s2_start_latency", 32'(n), 16);
        SW_RSTRT = 1'b1;
        step();
        SW_RSTRT = 1'b0;
        check("s5_sw_ignored_state", 32'(SEQ_STATE), 2);
        check("s5_sw_ignored_rstrt", 32'(CLK_ALGN_RSTRT), 0);
        BCLKSCLK_TRAIN_DONE = 1'b1;
        step();
        BCLKSCLK_TRAIN_DONE = 1'b0;
        check("s2_bit_train", 32'(SEQ_STATE), 3);
        BIT_ALGN_DONE = 1'b1;
        step();
        BIT_ALGN_DONE = 1'b0;
        check("s2_train_done", 32'(TRAIN_DONE), 1);
        check("s2_retry_cnt_kept", 32'(RETRY_CNT), 1);
        SW_RSTRT = 1'b1;
        step();
        SW_RSTRT = 1'b0;
        step();
        check("s2_restart_lock_wait", 32'(SEQ_STATE), 1);
        check("s2_restart_retry_clr", 32'(RETRY_CNT), 0);

        // Scenario 3: DONE_in never arrives. Two timeouts lead to FAIL.
        wait_start(100, n);
        check("s3_start_latency1", 32'(n), 16);
        count_start_high(n);
        check("s3_start_width1", 32'(n), 64);
        check("s3_retry1_state", 32'(SEQ_STATE), 4);
        check("s3_retry1_pulse", 32'(CLK_ALGN_RSTRT), 1);
        step();
        check("s3_retry_cnt1", 32'(RETRY_CNT), 1);
        wait_start(100, n);
        check("s3_start_latency2", 32'(n), 16);
        count_start_high(n);
        check("s3_start_width2", 32'(n), 64);
        check("s3_retry2_pulse", 32'(CLK_ALGN_RSTRT), 1);
        step();
        check("s3_state_fail", 32'(SEQ_STATE), 6);
        check("s3_train_err", 32'(TRAIN_ERR), 1);
        check("s3_retry_cnt2", 32'(RETRY_CNT), 2);
        check("s3_rstrt_end", 32'(CLK_ALGN_RSTRT), 0);
        repeat (5) step();
        check("s3_fail_sticky", 32'(TRAIN_ERR), 1);

        // SW restart from FAIL.
        SW_RSTRT = 1'b1;
        step();
        SW_RSTRT = 1'b0;
        check("sw_fail_state_rstrt", 32'(SEQ_STATE), 7);
        check("sw_fail_rstrt_pulse", 32'(CLK_ALGN_RSTRT), 1);
        check("sw_fail_err_low", 32'(TRAIN_ERR), 0);
        step();
        check("sw_fail_retry_clr", 32'(RETRY_CNT), 0);

        // Scenario 4: lock drops in BIT_TRAIN. RETRY_CNT must survive.
        wait_start(100, n);
        ICB_CLK_ALGN_ERR = 1'b1;
        step();
        ICB_CLK_ALGN_ERR = 1'b0;
        step();
        wait_start(100, n);
        BCLKSCLK_TRAIN_DONE = 1'b1;
        step();
        BCLKSCLK_TRAIN_DONE = 1'b0;
        check("s4_bit_train", 32'(SEQ_STATE), 3);
        PLL_LOCK = 1'b0;
        n = 0;
        while (BIT_ALGN_START && n < 10) begin
            step();
            n++;
        end
        check("s4_lock_loss_latency", 32'(n), 3);
        check("s4_state_idle", 32'(SEQ_STATE), 0);
        check("s4_retry_cnt_kept", 32'(RETRY_CNT), 1);
        PLL_LOCK = 1'b1;
        wait_start(100, n);
        check("s4_relock_latency", 32'(n), 19);

        // Scenario 6: asynchronous reset in the middle of CLK_TRAIN.
`ifdef IOD_RX_TRAIN_SEQ_ERRCNT_EN
        check("s6_err_events_pre", 32'(ERR_EVENT_CNT), 4);
`endif
        #2;
        RESETN = 1'b0;
        #1;
        check("s6_async_reset_outputs", all_outs(), 0);
`ifdef IOD_RX_TRAIN_SEQ_ERRCNT_EN
        check("s6_err_events_cleared", 32'(ERR_EVENT_CNT), 0);
`endif
        step();
        RESETN = 1'b1;
        wait_start(100, n);
        check("s6_post_reset_latency", 32'(n), 19);
`ifdef IOD_RX_TRAIN_SEQ_ERRCNT_EN
        for (int e = 0; e < 260; e++) begin
            wait_start(100, n);
            ICB_CLK_ALGN_ERR = 1'b1;
            step();
            ICB_CLK_ALGN_ERR = 1'b0;
            step();
            if (SEQ_STATE == 3'd6) begin
                SW_RSTRT = 1'b1;
                step();
                SW_RSTRT = 1'b0;
                step();
            end
        end
        check("s6_err_events_saturated", 32'(ERR_EVENT_CNT), 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
